traffic_phase_sched: RTL and testbench

// Phase scheduler for a two-road intersection with one pedestrian crossing.

---
 rtl/traffic_phase_sched.sv | 164 ++++++++++++++++
 tb/tb_traffic_phase_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sched.sv
// ---------------------------------------------------------------------------
// traffic_phase_sched
//
// Phase scheduler for a two-road intersection with one pedestrian crossing.
// It owns the phase timer, latches pedestrian requests, and decides which of
// road A, road B or the pedestrians has right-of-way. It also drives both
// lamp heads and the walk lamp.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   en_i           advance enable; low freezes state, timer and last_road
//   car_a_i        vehicle waiting on road A (level)
//   car_b_i        vehicle waiting on road B (level)
//   ped_req_i      pedestrian button (level or pulse)
//   lights_a_o     road A head {red,yellow,green}, one-hot
//   lights_b_o     road B head {red,yellow,green}, one-hot
//   walk_o         pedestrian walk lamp
//   ped_pending_o  pedestrian request latched and not yet served
//   phase_o        current state encoding (debug)
// ---------------------------------------------------------------------------
module traffic_phase_sched #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       car_a_i,
  input  logic       car_b_i,
  input  logic       ped_req_i,
  output logic [2:0] lights_a_o,
  output logic [2:0] lights_b_o,
  output logic       walk_o,
  output logic       ped_pending_o,
  output logic [2:0] phase_o
);

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    PED_WALK  = 3'd6,
    PED_CLEAR = 3'd7
  } state_e;

  localparam logic ROAD_A = 1'b0;
  localparam logic ROAD_B = 1'b1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pending_q, ped_pending_d;
  logic             last_road_q, last_road_d;
  logic [2:0]       lights_a_q, lights_b_q;
  logic             walk_q;
  logic             expire;

  // Dwell of a state minus one: the timer value loaded on entry, so that
  // the state is held exactly its dwell count of enabled cycles.
  function automatic logic [CNT_W-1:0] dwell_m1(input state_e s);
    case (s)
      A_GREEN, B_GREEN:   dwell_m1 = CNT_W'(GREEN_CYC - 1);
      A_YELLOW, B_YELLOW: dwell_m1 = CNT_W'(YELLOW_CYC - 1);
      PED_WALK:           dwell_m1 = CNT_W'(WALK_CYC - 1);
      default:            dwell_m1 = CNT_W'(ALLRED_CYC - 1);
    endcase
  endfunction

  // Lamp decode {lights_a, lights_b, walk} for a state. Every state that is
  // not a road green/yellow shows red on both heads, so walk can never
  // overlap a moving-traffic lamp.
  function automatic logic [6:0] lamps(input state_e s);
    case (s)
      A_GREEN:  lamps = {3'b001, 3'b100, 1'b0};
      A_YELLOW: lamps = {3'b010, 3'b100, 1'b0};
      B_GREEN:  lamps = {3'b100, 3'b001, 1'b0};
      B_YELLOW: lamps = {3'b100, 3'b010, 1'b0};
      PED_WALK: lamps = {3'b100, 3'b100, 1'b1};
      default:  lamps = {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  assign expire = (timer_q == '0);

  // Next-state, timer and request-latch logic. Greens only give way when
  // the opposite road or a pedestrian is waiting; otherwise the timer sits
  // saturated at zero so the handover happens as soon as demand appears.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    last_road_d   = last_road_q;
    ped_pending_d = ped_pending_q;

    if (en_i) begin
      if (!expire) begin
        timer_d = timer_q - 1'b1;
      end
      if (expire) begin
        case (state_q)
          A_GREEN:   if (car_b_i || ped_pending_q) state_d = A_YELLOW;
          A_YELLOW:  state_d = ALLRED_AB;
          ALLRED_AB: begin
            state_d     = ped_pending_q ? PED_WALK : B_GREEN;
            last_road_d = ROAD_A;
          end
          B_GREEN:   if (car_a_i || ped_pending_q) state_d = B_YELLOW;
          B_YELLOW:  state_d = ALLRED_BA;
          ALLRED_BA: begin
            state_d     = ped_pending_q ? PED_WALK : A_GREEN;
            last_road_d = ROAD_B;
          end
          PED_WALK:  state_d = PED_CLEAR;
          PED_CLEAR: state_d = (last_road_q == ROAD_A) ? B_GREEN : A_GREEN;
          default:   state_d = A_GREEN;
        endcase
      end
      // No state loops to itself, so any change of state is an entry.
      if (state_d != state_q) begin
        timer_d = dwell_m1(state_d);
      end
    end

    // Entering the walk serves the request, even if the button is still
    // pressed on that edge; the button is deaf for the rest of the walk.
    if (state_q != PED_WALK && state_d == PED_WALK) begin
      ped_pending_d = 1'b0;
    end else if (ped_req_i && state_q != PED_WALK) begin
      ped_pending_d = 1'b1;
    end
  end

  // State registers. Lamps are registered from the next state so they
  // switch on the same edge as the state itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= A_GREEN;
      timer_q       <= CNT_W'(GREEN_CYC - 1);
      ped_pending_q <= 1'b0;
      last_road_q   <= ROAD_A;
      lights_a_q    <= 3'b001;
      lights_b_q    <= 3'b100;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      last_road_q   <= last_road_d;
      {lights_a_q, lights_b_q, walk_q} <= lamps(state_d);
    end
  end

  assign lights_a_o    = lights_a_q;
  assign lights_b_o    = lights_b_q;
  assign walk_o        = walk_q;
  assign ped_pending_o = ped_pending_q;
  assign phase_o       = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_sched
//
// Directed bench for traffic_phase_sched with default parameters. Cycle k
// is the clock period after k enabled edges following the reset edge;
// inputs set during cycle k are sampled on the edge that ends it.
// ---------------------------------------------------------------------------
module tb_traffic_phase_sched;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       car_a_i;
  logic       car_b_i;
  logic       ped_req_i;
  logic [2:0] lights_a_o;
  logic [2:0] lights_b_o;
  logic       walk_o;
  logic       ped_pending_o;
  logic [2:0] phase_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  traffic_phase_sched dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .car_a_i       (car_a_i),
    .car_b_i       (car_b_i),
    .ped_req_i     (ped_req_i),
    .lights_a_o    (lights_a_o),
    .lights_b_o    (lights_b_o),
    .walk_o        (walk_o),
    .ped_pending_o (ped_pending_o),
    .phase_o       (phase_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  // Safety net so the run always ends even if a task stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected road A lamp for a phase, from the lamp table of the intersection.
  function automatic logic [2:0] exp_a(input int ph);
    case (ph)
      0:       exp_a = GRN;
      1:       exp_a = YEL;
      default: exp_a = RED;
    endcase
  endfunction

  function automatic logic [2:0] exp_b(input int ph);
    case (ph)
      3:       exp_b = GRN;
      4:       exp_b = YEL;
      default: exp_b = RED;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reset edge with quiet inputs; leaves the bench in cycle 0.
  task automatic do_reset();
    rst_i     = 1'b1;
    en_i      = 1'b1;
    car_a_i   = 1'b0;
    car_b_i   = 1'b0;
    ped_req_i = 1'b0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (phase_o !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_phase: got %0d expected 0", phase_o);
    end
    n_checks++;
    if (lights_a_o !== GRN || lights_b_o !== RED) begin
      n_fail++;
      $display("[TB] FAIL reset_lights: got a=%b b=%b expected a=001 b=100", lights_a_o, lights_b_o);
    end
    n_checks++;
    if (walk_o !== 1'b0 || ped_pending_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_walk_pending: got walk=%b pend=%b expected 0 0", walk_o, ped_pending_o);
    end
  endtask

  // No demand: A stays green; once the timer has saturated, demand from
  // road B hands over on the very next edge.
  task automatic test_no_demand();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      n_checks++;
      if (phase_o !== 3'd0 || lights_a_o !== GRN || lights_b_o !== RED || walk_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL no_demand cycle %0d: got ph=%0d a=%b b=%b w=%b expected ph=0 a=001 b=100 w=0",
                 k, phase_o, lights_a_o, lights_b_o, walk_o);
      end
      step();
    end
    car_b_i = 1'b1;
    step();
    n_checks++;
    if (phase_o !== 3'd1 || lights_a_o !== YEL) begin
      n_fail++;
      $display("[TB] FAIL held_timer_handover: got ph=%0d a=%b expected ph=1 a=010", phase_o, lights_a_o);
    end
  endtask

  task automatic test_car_b();
    int ph;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      car_b_i = 1'b1;
      ph = (k <= 7) ? 0 : (k <= 9) ? 1 : (k == 10) ? 2 : 3;
      n_checks++;
      if (phase_o !== 3'(ph) || lights_a_o !== exp_a(ph) || lights_b_o !== exp_b(ph) || walk_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL car_b cycle %0d: got ph=%0d a=%b b=%b w=%b expected ph=%0d a=%b b=%b w=0",
                 k, phase_o, lights_a_o, lights_b_o, walk_o, ph, exp_a(ph), exp_b(ph));
      end
      step();
    end
  endtask

  // Pulses at 3 (latched), 10 (same edge as walk entry: clear wins),
  // 12 (during walk: ignored) and 15 (during clearance: latched again).
  task automatic test_ped_pulse();
    int   ph;
    logic pend;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      ped_req_i = (k == 3 || k == 10 || k == 12 || k == 15);
      ph   = (k <= 7) ? 0 : (k <= 9) ? 1 : (k == 10) ? 2 : (k <= 14) ? 6 : (k == 15) ? 7 : 3;
      pend = (k >= 4 && k <= 10) || (k == 16);
      n_checks++;
      if (phase_o !== 3'(ph) || lights_a_o !== exp_a(ph) || lights_b_o !== exp_b(ph)) begin
        n_fail++;
        $display("[TB] FAIL ped_phase cycle %0d: got ph=%0d a=%b b=%b expected ph=%0d a=%b b=%b",
                 k, phase_o, lights_a_o, lights_b_o, ph, exp_a(ph), exp_b(ph));
      end
      n_checks++;
      if (walk_o !== (ph == 6) || ped_pending_o !== pend) begin
        n_fail++;
        $display("[TB] FAIL ped_walk_pending cycle %0d: got w=%b p=%b expected w=%b p=%b",
                 k, walk_o, ped_pending_o, (ph == 6), pend);
      end
      step();
    end
    ped_req_i = 1'b0;
  endtask

  task automatic test_enable_freeze();
    int ph;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      car_b_i = 1'b1;
      en_i    = !(k >= 8 && k <= 12);
      ph = (k <= 7) ? 0 : (k <= 14) ? 1 : (k == 15) ? 2 : 3;
      n_checks++;
      if (phase_o !== 3'(ph) || lights_a_o !== exp_a(ph) || lights_b_o !== exp_b(ph)) begin
        n_fail++;
        $display("[TB] FAIL freeze cycle %0d: got ph=%0d a=%b b=%b expected ph=%0d a=%b b=%b",
                 k, phase_o, lights_a_o, lights_b_o, ph, exp_a(ph), exp_b(ph));
      end
      step();
    end
    en_i = 1'b1;
  endtask

  task automatic test_reset_mid_phase();
    // Reset during B_GREEN with a pending request.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      car_b_i   = 1'b1;
      ped_req_i = (k == 12);
      step();
    end
    ped_req_i = 1'b0;
    n_checks++;
    if (phase_o !== 3'd3 || ped_pending_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset cycle 13: got ph=%0d p=%b expected ph=3 p=1", phase_o, ped_pending_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_checks++;
    if (phase_o !== 3'd0 || lights_a_o !== GRN || lights_b_o !== RED || ped_pending_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_from_b_green: got ph=%0d a=%b b=%b p=%b expected ph=0 a=001 b=100 p=0",
               phase_o, lights_a_o, lights_b_o, ped_pending_o);
    end

    // Reset during PED_WALK.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      ped_req_i = (k == 0);
      step();
    end
    ped_req_i = 1'b0;
    n_checks++;
    if (phase_o !== 3'd6 || walk_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_walk cycle 12: got ph=%0d w=%b expected ph=6 w=1", phase_o, walk_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_checks++;
    if (phase_o !== 3'd0 || walk_o !== 1'b0 || lights_a_o !== GRN || lights_b_o !== RED) begin
      n_fail++;
      $display("[TB] FAIL reset_from_walk: got ph=%0d w=%b a=%b b=%b expected ph=0 w=0 a=001 b=100",
               phase_o, walk_o, lights_a_o, lights_b_o);
    end
  endtask

  // All demand held: A, walk, B, walk, A ... with a period of 32 cycles.
  task automatic test_rotation();
    int ph;
    int m;
    do_reset();
    for (int k = 0; k <= 41; k++) begin
      car_a_i   = 1'b1;
      car_b_i   = 1'b1;
      ped_req_i = 1'b1;
      m  = k % 32;
      ph = (m <= 7)  ? 0 : (m <= 9)  ? 1 : (m == 10) ? 2 : (m <= 14) ? 6 :
           (m == 15) ? 7 : (m <= 23) ? 3 : (m <= 25) ? 4 : (m == 26) ? 5 :
           (m <= 30) ? 6 : 7;
      n_checks++;
      if (phase_o !== 3'(ph)) begin
        n_fail++;
        $display("[TB] FAIL rotation cycle %0d: got ph=%0d expected ph=%0d", k, phase_o, ph);
      end
      n_checks++;
      if (walk_o === 1'b1 && (lights_a_o !== RED || lights_b_o !== RED)) begin
        n_fail++;
        $display("[TB] FAIL walk_conflict cycle %0d: got w=1 a=%b b=%b expected both 100", k, lights_a_o, lights_b_o);
      end
      n_checks++;
      if (lights_a_o !== RED && lights_b_o !== RED) begin
        n_fail++;
        $display("[TB] FAIL head_conflict cycle %0d: got a=%b b=%b expected at least one 100", k, lights_a_o, lights_b_o);
      end
      step();
    end
    car_a_i   = 1'b0;
    car_b_i   = 1'b0;
    ped_req_i = 1'b0;
  endtask

  initial begin
    rst_i     = 1'b1;
    en_i      = 1'b1;
    car_a_i   = 1'b0;
    car_b_i   = 1'b0;
    ped_req_i = 1'b0;
    #2;
    test_reset();
    test_no_demand();
    test_car_b();
    test_ped_pulse();
    test_enable_freeze();
    test_reset_mid_phase();
    test_rotation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
